// File: rtl/hawk_line_swapper_if.sv
// Line-stream bundle for hawk_line_swapper: input line channel plus transformed output channel.
// master drives input lines and downstream ready; slave is the swapper side.
interface hawk_line_swapper_if #(
    parameter int DATA_W = 512
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic [DATA_W/8-1:0]   in_strb;
    logic [1:0]            in_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [DATA_W/8-1:0]   out_strb;

    modport master (
        output in_valid, in_data, in_strb, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_strb
    );

    modport slave (
        input  in_valid, in_data, in_strb, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_strb
    );
endinterface

// File: rtl/hawk_line_swapper.sv
// Registered byte-swap / byte-reverse of whole lines with handshake counter and sticky mode-3 flag.
// Optional HAWK_SWAP_SKID_EN adds a skid entry so in_ready_o no longer depends on out_ready_i.
module hawk_line_swapper #(
    parameter int DATA_W     = 512,
    parameter int SWAP_BYTES = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_W-1:0]   in_data_i,
    input  logic [DATA_W/8-1:0] in_strb_i,
    input  logic [1:0]          in_mode_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_W-1:0]   out_data_o,
    output logic [DATA_W/8-1:0] out_strb_o,
    input  logic                clr_i,
    output logic [31:0]         xfer_cnt_o,
    output logic                mode_err_o
);
    localparam int NB = DATA_W / 8;
    localparam int SB = (SWAP_BYTES > 0) ? SWAP_BYTES : 1;

    if (DATA_W < 8 || (DATA_W % 8) != 0 || SWAP_BYTES < 1 || (NB % SB) != 0) begin : g_bad_cfg
        $fatal(1, "hawk_line_swapper: DATA_W must be a multiple of 8 and SWAP_BYTES must divide DATA_W/8");
    end

    // Handshakes: a line moves on a channel in any cycle where valid and ready are both 1;
    // valid never waits on ready, and a stalled output holds data/strobe until taken.
    logic                in_fire;
    logic                out_fire;
    logic [DATA_W-1:0]   xf_data;
    logic [NB-1:0]       xf_strb;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [NB-1:0]       out_strb_q;
    logic [31:0]         cnt_q;
    logic                err_q;

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_q && out_ready_i;

    // Both mappings are involutions, so output byte b simply picks input byte ws/rv.
    for (genvar b = 0; b < NB; b++) begin : g_byte
        localparam int WS = (b / SB) * SB + (SB - 1 - (b % SB));
        localparam int RV = NB - 1 - b;
        assign xf_data[8*b +: 8] = (in_mode_i == 2'd1) ? in_data_i[8*WS +: 8] :
                                   (in_mode_i == 2'd2) ? in_data_i[8*RV +: 8] :
                                                         in_data_i[8*b +: 8];
        assign xf_strb[b]        = (in_mode_i == 2'd1) ? in_strb_i[WS] :
                                   (in_mode_i == 2'd2) ? in_strb_i[RV] :
                                                         in_strb_i[b];
    end

`ifdef HAWK_SWAP_SKID_EN
    logic                skid_valid_q;
    logic [DATA_W-1:0]   skid_data_q;
    logic [NB-1:0]       skid_strb_q;

    assign in_ready_o = !skid_valid_q && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready_i) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                out_strb_q   <= skid_strb_q;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_fire;
                if (in_fire) begin
                    out_data_q <= xf_data;
                    out_strb_q <= xf_strb;
                end
            end
        end else if (in_fire) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= xf_data;
            skid_strb_q  <= xf_strb;
        end
    end
`else
    assign in_ready_o = !rst_i && (!out_valid_q || out_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
        end else if (in_ready_o) begin
            out_valid_q <= in_valid_i;
            if (in_valid_i) begin
                out_data_q <= xf_data;
                out_strb_q <= xf_strb;
            end
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= 32'd0;
            err_q <= 1'b0;
        end else begin
            if (out_fire) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (in_fire && in_mode_i == 2'd3) begin
                err_q <= 1'b1;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_strb_o  = out_strb_q;
    assign xfer_cnt_o  = cnt_q;
    assign mode_err_o  = err_q;
endmodule
